// File: rtl/wb_stream_fifo_regs_if.sv
// Bus bundle for wb_stream_fifo_regs: Wishbone register port plus the TX and RX byte streams.
// The slave modport is the register block's view; the master modport is the host/stream-partner view.
interface wb_stream_fifo_regs_if #(
    parameter int WB_ADDR_WIDTH = 32
);
    logic [WB_ADDR_WIDTH-1:0] wb_adr_i;
    logic [31:0]              wb_dat_i;
    logic [31:0]              wb_dat_o;
    logic                     wb_we_i;
    logic                     wb_stb_i;
    logic                     wb_cyc_i;
    logic [3:0]               wb_sel_i;
    logic                     wb_ack_o;
    logic                     wb_err_o;

    logic [7:0]               m_axis_tdata;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;

    logic [7:0]               s_axis_tdata;
    logic                     s_axis_tvalid;
    logic                     s_axis_tready;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output m_axis_tdata, m_axis_tvalid,
        input  m_axis_tready,
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  m_axis_tdata, m_axis_tvalid,
        output m_axis_tready,
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready
    );
endinterface

// File: rtl/wb_stream_fifo_regs.sv
// Wishbone register block bridging a TX byte FIFO (to m_axis) and an RX byte FIFO (from s_axis),
// with STATUS/CONTROL/SCRATCH registers and single-cycle-latency registered ack/err.
module wb_stream_fifo_regs #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_stream_fifo_regs_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    logic        ack_reg, ack_next;
    logic        err_reg, err_next;
    logic [31:0] dat_reg, dat_next;
    logic        tx_overflow_reg;
    logic [31:0] scratch_value;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [PW:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [PW:0] rx_wr_ptr_reg, rx_rd_ptr_reg;

    logic        req, addr_bad, is_err, wr_ok, rd_ok;
    logic [1:0]  reg_sel;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic [PW:0] tx_level, rx_level;
    logic [7:0]  rx_head;
    logic        data_wr, ctrl_wr, scratch_wr;
    logic        tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
    logic        ovf_set, ovf_clr;
    logic [31:0] status_word;
    logic        unused_adr_lsbs;

    // A request is only taken while no termination is showing, so each access is served exactly once.
    assign req      = bus.wb_cyc_i & bus.wb_stb_i & ~ack_reg & ~err_reg;
    assign reg_sel  = bus.wb_adr_i[3:2];
    assign addr_bad = |bus.wb_adr_i[WB_ADDR_WIDTH-1:4];
    assign is_err   = addr_bad | (bus.wb_we_i & (reg_sel == REG_STATUS));
    assign wr_ok    = req & ~is_err & bus.wb_we_i;
    assign rd_ok    = req & ~is_err & ~bus.wb_we_i;
    assign unused_adr_lsbs = ^bus.wb_adr_i[1:0];

    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[PW] != tx_rd_ptr_reg[PW]) &&
                      (tx_wr_ptr_reg[PW-1:0] == tx_rd_ptr_reg[PW-1:0]);
    assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full  = (rx_wr_ptr_reg[PW] != rx_rd_ptr_reg[PW]) &&
                      (rx_wr_ptr_reg[PW-1:0] == rx_rd_ptr_reg[PW-1:0]);
    assign tx_level = tx_wr_ptr_reg - tx_rd_ptr_reg;
    assign rx_level = rx_wr_ptr_reg - rx_rd_ptr_reg;
    assign rx_head  = rx_mem[rx_rd_ptr_reg[PW-1:0]];

    assign data_wr    = wr_ok & (reg_sel == REG_DATA) & bus.wb_sel_i[0];
    assign ctrl_wr    = wr_ok & (reg_sel == REG_CONTROL) & bus.wb_sel_i[0];
    assign scratch_wr = wr_ok & (reg_sel == REG_SCRATCH);

    // A full TX FIFO still acks the write; the byte is lost and the overflow flag records it.
    assign tx_push  = data_wr & ~tx_full;
    assign ovf_set  = data_wr & tx_full;
    assign tx_flush = ctrl_wr & bus.wb_dat_i[0];
    assign rx_flush = ctrl_wr & bus.wb_dat_i[1];
    assign ovf_clr  = ctrl_wr & bus.wb_dat_i[2];
    assign tx_pop   = ~tx_empty & bus.m_axis_tready;
    assign rx_push  = bus.s_axis_tvalid & ~rx_full;
    assign rx_pop   = rd_ok & (reg_sel == REG_DATA) & ~rx_empty;

    assign status_word = {8'd0, 8'(rx_level), 8'(tx_level), 3'd0,
                          tx_overflow_reg, rx_full, rx_empty, tx_full, tx_empty};

    assign bus.m_axis_tvalid = ~tx_empty;
    assign bus.m_axis_tdata  = tx_mem[tx_rd_ptr_reg[PW-1:0]];
    assign bus.s_axis_tready = ~rx_full;
    assign bus.wb_ack_o      = ack_reg;
    assign bus.wb_err_o      = err_reg;
    assign bus.wb_dat_o      = dat_reg;

    always_comb begin
        ack_next = 1'b0;
        err_next = 1'b0;
        dat_next = 32'd0;
        if (req) begin
            if (is_err) begin
                err_next = 1'b1;
            end else begin
                ack_next = 1'b1;
                if (!bus.wb_we_i) begin
                    case (reg_sel)
                        REG_DATA:    dat_next = rx_empty ? 32'd0 : {1'b1, 23'd0, rx_head};
                        REG_STATUS:  dat_next = status_word;
                        REG_CONTROL: dat_next = 32'd0;
                        default:     dat_next = scratch_value;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            dat_reg <= 32'd0;
        end else begin
            ack_reg <= ack_next;
            err_reg <= err_next;
            dat_reg <= dat_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow_reg <= 1'b0;
        end else if (ovf_set) begin
            tx_overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            tx_overflow_reg <= 1'b0;
        end
    end

    // Flush wins over any concurrent push or pop of the same FIFO.
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg[PW-1:0]] <= bus.wb_dat_i[7:0];
        if (rx_push) rx_mem[rx_wr_ptr_reg[PW-1:0]] <= bus.s_axis_tdata;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scratch
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    byte_reg <= 8'd0;
                end else if (scratch_wr && bus.wb_sel_i[gi]) begin
                    byte_reg <= bus.wb_dat_i[gi*8 +: 8];
                end
            end
            assign scratch_value[gi*8 +: 8] = byte_reg;
        end
    endgenerate
endmodule
